mux16_scan_serializer: RTL and testbench
========================================

Name: mux16_scan_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of and around the team's 16:1 single-bit mux.
- Accepts a 16-bit word over a valid/ready handshake and holds it on the mux data input.
- Steps the mux 4-bit select through all 16 positions.
- Presents the selected bit as a serial stream with valid/ready/last framing to downstream logic.

Parameters:
- MSB_FIRST, 0, 0 = select order 0..15 (LSB first); 1 = select order 15..0.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream word valid.
- in_data  input  16  upstream word.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  synchronous abort of the current frame.
- mux_in  output  16  held word, wired to the mux data input.
- mux_s  output  4  mux select, registered.
- mux_out  input  1  mux output bit; the mux is combinational.
- ser_data  output  1  serial bit; equals mux_out combinationally.
- ser_valid  output  1  ser_data is valid.
- ser_last  output  1  current beat is bit 16 of 16 in the frame.
- ser_ready  input  1  downstream accepts the beat.
- busy  output  1  frame in progress.
- frame_cnt  output  CNT_W  count of fully transmitted frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; hold register=0 (so mux_in=0).
  - beat counter=0; mux_s=(MSB_FIRST?15:0).
  - frame_cnt=0; ser_valid=0; ser_last=0; busy=0.
  - Reset mid-frame drops the frame with no further beats.
- States: IDLE and SHIFT only.
- IDLE:
  - Outputs: in_ready=1, ser_valid=0, busy=0.
  - On in_valid=1, latch in_data into the hold register, set beat counter=0, set mux_s to the first index, then go to SHIFT.
  - First beat is valid the cycle after acceptance (latency 1).
- SHIFT:
  - Outputs: ser_valid=1, busy=1, ser_data=mux_out.
  - Select index: mux_s = MSB_FIRST ? 15-count : count.
  - ser_last = (count==15).
  - A beat transfers when ser_valid & ser_ready.
  - On a non-last transfer: count+1, and mux_s updates to the next index at the same edge.
  - While ser_ready=0: count, mux_s, mux_in and ser_data stay stable. A valid beat is never withdrawn.
- Last-beat transfer:
  - frame_cnt increments at the same edge, wrapping at 2^CNT_W.
  - in_ready = (state==IDLE) | (state==SHIFT & ser_last & ser_ready). This is a combinational path from ser_ready.
  - If in_valid=1 on the last transfer: the new word is latched, count=0, mux_s=first index, and state stays SHIFT. No idle cycle; back-to-back frames give 1 beat per cycle.
  - Otherwise go to IDLE. mux_in and mux_s keep their last values in IDLE.
- in_valid during SHIFT before the last transfer: in_ready=0 and the word is not taken.
- flush=1:
  - At the next edge, go to IDLE.
  - Clear ser_valid; set count=0; set mux_s to the first index.
  - frame_cnt is unchanged and the hold register is unchanged.
  - flush has priority over a last-beat transfer and over word acceptance in the same cycle; the frame is not counted.
  - in_ready=0 while flush=1.
- Priority order: rst_n > flush > handshake.
- mux_out is sampled only through ser_data. The block assumes the mux settles within one cycle of a mux_s/mux_in change.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, ser_valid=0, busy=0, mux_s=0, mux_in=0, frame_cnt=0, and no word accepted.
2. MSB_FIRST=0, ser_ready=1, word 16'hA5C3 -> ser_valid asserted 1 cycle after accept; 16 consecutive beats 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; mux_s runs 0..15; ser_last only on beat 16; frame_cnt=1; in_ready=1 after.
3. Backpressure: word 16'h00FF with ser_ready pattern 1,0,0,1 repeating -> mux_s and ser_data frozen during ready=0; exactly 16 transfers; beats 1-8 =1, beats 9-16 =0.
4. Back-to-back: 16'hFFFF then 16'h0000, with the second in_valid held during the first frame's last beat -> second word accepted on that beat; 32 beats in 32 cycles (16 ones, then 16 zeros); frame_cnt=2; in_valid ignored during beats 1-15.
5. MSB_FIRST=1, word 16'h8001 -> mux_s runs 15..0; beats 1,0 (x14),1; ser_last on the mux_s=0 beat.
6. Abort: flush after beat 5 of 16'h1234 -> IDLE next cycle, ser_valid=0, frame_cnt unchanged. Then rst_n=0 after beat 3 of a new frame -> ser_valid=0 and frame_cnt=0 next cycle.

Source files
------------

// File: rtl/mux16_scan_serializer.sv
// -----------------------------------------------------------------------------
// mux16_scan_serializer
//
// Parallel-to-serial stage wrapped around an external combinational 16:1
// single-bit mux. A 16-bit word is accepted over a valid/ready handshake and
// held on the mux data input. The registered mux select then steps through all
// 16 positions, and the selected bit is forwarded as a serial stream with
// valid/ready/last framing.
//
// Parameters:
//   MSB_FIRST  0: select order 0..15, 1: select order 15..0
//   CNT_W      width of the completed-frame counter (wraps)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream word valid
//   in_data    upstream 16-bit word
//   in_ready   word can be accepted this cycle (combinational from ser_ready)
//   flush      synchronous abort of the current frame
//   mux_in     held word, drives the mux data input
//   mux_s      registered mux select
//   mux_out    mux output bit (external combinational mux)
//   ser_data   serial bit, equal to mux_out
//   ser_valid  ser_data is valid
//   ser_last   current beat is the 16th beat of the frame
//   ser_ready  downstream accepts the beat
//   busy       frame in progress
//   frame_cnt  number of fully transmitted frames, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mux16_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic [15:0]      mux_in,
    output logic [3:0]       mux_s,
    input  logic             mux_out,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] FIRST_IDX = MSB_FIRST ? 4'd15 : 4'd0;

    // Maps the beat count onto the mux select position.
    function automatic logic [3:0] idx_of(input logic [3:0] c);
        return MSB_FIRST ? (4'd15 - c) : c;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_hold, w_hold_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [3:0]       r_mux_s, w_mux_s_nxt;
    logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;

    logic w_shift;
    logic w_last;
    logic w_xfer;
    logic w_accept;
    logic w_frame_done;

    assign w_shift      = (r_state == SHIFT);
    assign w_last       = w_shift & (r_cnt == 4'd15);
    // flush outranks the handshake, so a beat never transfers under flush.
    assign w_xfer       = w_shift & ser_ready & ~flush;
    assign w_frame_done = w_xfer & w_last;
    // A new word can slip in on the last transfer so frames run back-to-back.
    assign in_ready     = ~flush & (~w_shift | (w_last & ser_ready));
    assign w_accept     = in_valid & in_ready;

    // Next-state and datapath update.
    // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold;
        w_cnt_nxt       = r_cnt;
        w_mux_s_nxt     = r_mux_s;
        w_frame_cnt_nxt = r_frame_cnt;

        if (w_frame_done) begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end

        if (flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
            w_mux_s_nxt = FIRST_IDX;
        end else if (w_accept) begin
            w_state_nxt = SHIFT;
            w_hold_nxt  = in_data;
            w_cnt_nxt   = 4'd0;
            w_mux_s_nxt = FIRST_IDX;
        end else if (w_xfer) begin
            if (w_last) begin
                // mux_in and mux_s keep their last values while idle.
                w_state_nxt = IDLE;
            end else begin
                w_cnt_nxt   = r_cnt + 4'd1;
                w_mux_s_nxt = idx_of(r_cnt + 4'd1);
            end
        end
    end

    // State register with synchronous reset.
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold      <= 16'd0;
            r_cnt       <= 4'd0;
            r_mux_s     <= FIRST_IDX;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mux_s     <= w_mux_s_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    assign mux_in    = r_hold;
    assign mux_s     = r_mux_s;
    assign ser_data  = mux_out;
    assign ser_valid = w_shift;
    assign ser_last  = w_last;
    assign busy      = w_shift;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// -----------------------------------------------------------------------------
// tb_mux16_scan_serializer
//
// Two instances share all stimulus: u_lsb (MSB_FIRST=0, CNT_W=8) and
// u_msb (MSB_FIRST=1, CNT_W=2, so the frame counter wraps quickly). Each has a
// behavioural 16:1 mux on its mux_in/mux_s. Stimulus pushes hand-computed beat
// sequences into per-instance queues; a negedge monitor compares every
// presented beat (data, last, select) with the queue head and pops on transfer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux16_scan_serializer;

    typedef struct packed {
        logic       data;
        logic       last;
        logic [3:0] sel;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        flush;
    logic        ser_ready;

    logic [1:0]  in_ready;
    logic [1:0]  ser_data;
    logic [1:0]  ser_valid;
    logic [1:0]  ser_last;
    logic [1:0]  busy;
    logic [1:0]  mux_out;
    logic [15:0] mux_in [2];
    logic [3:0]  mux_s  [2];
    logic [7:0]  fc0;
    logic [1:0]  fc1;

    beat_t exp_q [2][$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_xfer   = 0;
    int    cyc      = 0;
    int    t_last_xfer = 0;
    logic  bp_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the external combinational mux.
    assign mux_out[0] = mux_in[0][mux_s[0]];
    assign mux_out[1] = mux_in[1][mux_s[1]];

    mux16_scan_serializer #(.MSB_FIRST(1'b0), .CNT_W(8)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[0]), .flush(flush), .mux_in(mux_in[0]), .mux_s(mux_s[0]),
        .mux_out(mux_out[0]), .ser_data(ser_data[0]), .ser_valid(ser_valid[0]),
        .ser_last(ser_last[0]), .ser_ready(ser_ready), .busy(busy[0]), .frame_cnt(fc0)
    );

    mux16_scan_serializer #(.MSB_FIRST(1'b1), .CNT_W(2)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready[1]), .flush(flush), .mux_in(mux_in[1]), .mux_s(mux_s[1]),
        .mux_out(mux_out[1]), .ser_data(ser_data[1]), .ser_valid(ser_valid[1]),
        .ser_last(ser_last[1]), .ser_ready(ser_ready), .busy(busy[1]), .frame_cnt(fc1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Downstream ready: constant 1, or the repeating pattern 1,0,0,1.
    initial begin
        logic [3:0] bp_pat;
        logic [1:0] bp_ph;
        bp_pat    = 4'b1001;
        bp_ph     = 2'd0;
        ser_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                ser_ready = bp_pat[bp_ph];
                bp_ph     = bp_ph + 2'd1;
            end else begin
                ser_ready = 1'b1;
            end
        end
    end

    // Monitor: every presented beat must match the queue head; pop on transfer.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1 && flush === 1'b0) begin
            for (int k = 0; k < 2; k++) begin
                if (ser_valid[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        check($sformatf("u%0d_beat_expected", k), 32'(exp_q[k].size()), 32'd1);
                    end else begin
                        e = exp_q[k][0];
                        check($sformatf("u%0d_ser_data", k), 32'(ser_data[k]), 32'(e.data));
                        check($sformatf("u%0d_ser_last", k), 32'(ser_last[k]), 32'(e.last));
                        check($sformatf("u%0d_mux_s", k),    32'(mux_s[k]),    32'(e.sel));
                        if (ser_ready) begin
                            void'(exp_q[k].pop_front());
                            if (k == 0) begin
                                n_xfer++;
                                t_last_xfer = cyc;
                            end
                        end
                    end
                end
            end
        end
    end

    // Queue the first nb expected beats (beat i at bit i-1) and offer the word.
    task automatic send_word(input logic [15:0] w, input logic [15:0] lsb_beats,
                             input logic [15:0] msb_beats, input int nb);
        beat_t be;
        bit    done;
        done = 1'b0;
        for (int b = 0; b < nb; b++) begin
            be.data = lsb_beats[b];
            be.last = (b == 15);
            be.sel  = 4'(b);
            exp_q[0].push_back(be);
            be.data = msb_beats[b];
            be.sel  = 4'(15 - b);
            exp_q[1].push_back(be);
        end
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready[0]) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check($sformatf("accept_%h", w), 32'(in_ready[0]), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && busy == 2'b00) break;
        end
        check({name, "_drain_u0"}, 32'(exp_q[0].size()), 32'd0);
        check({name, "_drain_u1"}, 32'(exp_q[1].size()), 32'd0);
        check({name, "_busy"},     32'(busy),            32'd0);
    endtask

    initial begin
        int x0, c0, c1;
        // 1. Reset with in_valid held high.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'h3);
        check("rst_ser_valid", 32'(ser_valid), 32'h0);
        check("rst_ser_last",  32'(ser_last),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_mux_s_u0",  32'(mux_s[0]),  32'd0);
        check("rst_mux_s_u1",  32'(mux_s[1]),  32'd15);
        check("rst_mux_in_u0", 32'(mux_in[0]), 32'h0);
        check("rst_mux_in_u1", 32'(mux_in[1]), 32'h0);
        check("rst_fc_u0",     32'(fc0),       32'd0);
        check("rst_fc_u1",     32'(fc1),       32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_no_accept", 32'(ser_valid), 32'h0);

        // 2. Single frame, full-rate ready.
        send_word(16'hA5C3, 16'hA5C3, 16'hC3A5, 16);
        check("t2_latency", 32'(ser_valid), 32'h3);
        wait_drain("t2");
        check("t2_fc_u0",    32'(fc0),      32'd1);
        check("t2_fc_u1",    32'(fc1),      32'd1);
        check("t2_in_ready", 32'(in_ready), 32'h3);

        // 3. Backpressure with ready pattern 1,0,0,1.
        bp_en = 1'b1;
        send_word(16'h00FF, 16'h00FF, 16'hFF00, 16);
        wait_drain("t3");
        bp_en = 1'b0;
        check("t3_fc_u0", 32'(fc0), 32'd2);
        check("t3_fc_u1", 32'(fc1), 32'd2);

        // 4. Back-to-back frames; second word offered throughout the first.
        x0 = n_xfer;
        send_word(16'hFFFF, 16'hFFFF, 16'hFFFF, 16);
        c0 = cyc;
        send_word(16'h0000, 16'h0000, 16'h0000, 16);
        c1 = cyc;
        check("t4_accept_on_last", 32'(c1 - c0), 32'd16);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (n_xfer >= x0 + 32) break;
        end
        check("t4_beats",   32'(n_xfer - x0),      32'd32);
        check("t4_cycles",  32'(t_last_xfer - c0), 32'd31);
        wait_drain("t4");
        check("t4_fc_u0", 32'(fc0), 32'd4);
        check("t4_fc_u1", 32'(fc1), 32'd0);

        // 5. Endpoint bits set; select order differs per instance.
        send_word(16'h8001, 16'h8001, 16'h8001, 16);
        wait_drain("t5");
        check("t5_fc_u0", 32'(fc0), 32'd5);
        check("t5_fc_u1", 32'(fc1), 32'd1);

        // 6a. Flush after beat 5, with a competing word offered.
        send_word(16'h1234, 16'h1234, 16'h2C48, 5);
        repeat (5) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        #1;
        check("t6_in_ready_flush", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_ser_valid",  32'(ser_valid), 32'h0);
        check("t6_busy",       32'(busy),      32'h0);
        check("t6_fc_u0",      32'(fc0),       32'd5);
        check("t6_fc_u1",      32'(fc1),       32'd1);
        check("t6_mux_s_u0",   32'(mux_s[0]),  32'd0);
        check("t6_mux_s_u1",   32'(mux_s[1]),  32'd15);
        check("t6_mux_in_u0",  32'(mux_in[0]), 32'h1234);
        check("t6_mux_in_u1",  32'(mux_in[1]), 32'h1234);
        check("t6_q_u0",       32'(exp_q[0].size()), 32'd0);
        check("t6_q_u1",       32'(exp_q[1].size()), 32'd0);

        // 6b. Reset after beat 3 of a new frame.
        send_word(16'h5A5A, 16'h5A5A, 16'h5A5A, 3);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6r_ser_valid", 32'(ser_valid), 32'h0);
        check("t6r_fc_u0",     32'(fc0),       32'd0);
        check("t6r_fc_u1",     32'(fc1),       32'd0);
        check("t6r_mux_in_u0", 32'(mux_in[0]), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6r_no_resume", 32'(ser_valid), 32'h0);
        check("end_q_u0", 32'(exp_q[0].size()), 32'd0);
        check("end_q_u1", 32'(exp_q[1].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
